// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared UART TX unit.
// master is the arbiter's view; slave is the view of the surrounding logic.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [1:0]           cfg_parity_type;
    logic [1:0]           cfg_baud_rate;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   err;
    logic                 busy;
    logic [IW-1:0]        grant_id;
    logic                 tx_send;
    logic [7:0]           tx_data;
    logic [1:0]           tx_parity_type;
    logic [1:0]           tx_baud_rate;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        input  req, req_data, cfg_parity_type, cfg_baud_rate, tx_active, tx_done,
        output ack, err, busy, grant_id, tx_send, tx_data, tx_parity_type, tx_baud_rate
    );

    modport slave (
        output req, req_data, cfg_parity_type, cfg_baud_rate, tx_active, tx_done,
        input  ack, err, busy, grant_id, tx_send, tx_data, tx_parity_type, tx_baud_rate
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
//   state   | meaning
//   S_IDLE  | config tracks cfg_*, arbitrate pending requests
//   S_START | tx_send high, waiting for tx_active or start timeout
//   S_WAIT  | frame in flight, waiting for tx_done with tx_active low
//   S_DONE  | one-cycle ack to the granted requester
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_last;
    logic [15:0]   r_cnt;
    logic [7:0]    r_data;
    logic [1:0]    r_parity;
    logic [1:0]    r_baud;

    logic               w_any;
    logic [IW-1:0]      w_winner;
    logic [7:0]         w_win_data;
    logic               w_timeout;
    logic               w_cfg_load;
    logic [NUM_REQ-1:0] w_grant_oh;

    // First set request after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_any && bus.req[IW'(v_idx)]) begin
                w_any    = 1'b1;
                w_winner = IW'(v_idx);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IW'(i)) begin
                w_win_data = bus.req_data[8*i +: 8];
            end
        end
    end

    assign w_timeout  = (r_state == S_START) && !bus.tx_active &&
                        (r_cnt == 16'(START_TIMEOUT));
    // Loading on the edge into IDLE makes new cfg visible in the first IDLE cycle.
    assign w_cfg_load = (r_state == S_IDLE) || (w_state_next == S_IDLE);
    assign w_grant_oh = NUM_REQ'(1) << r_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_next = S_START;
            S_START: begin
                if (bus.tx_active)  w_state_next = S_WAIT;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_WAIT:  if (!bus.tx_active && bus.tx_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state != S_IDLE);
        bus.tx_send = (r_state == S_START) && !w_timeout;
        bus.ack     = (r_state == S_DONE) ? w_grant_oh : '0;
        bus.err     = w_timeout ? w_grant_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_last   <= IW'(NUM_REQ - 1);
            r_cnt    <= '0;
            r_data   <= '0;
            r_parity <= '0;
            r_baud   <= '0;
        end else begin
            if (w_cfg_load) begin
                r_parity <= bus.cfg_parity_type;
                r_baud   <= bus.cfg_baud_rate;
            end
            if ((r_state == S_IDLE) && w_any) begin
                r_data  <= w_win_data;
                r_grant <= w_winner;
            end
            if (r_state == S_START) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_DONE) || w_timeout) begin
                r_last <= r_grant;
            end
        end
    end

    assign bus.grant_id       = r_grant;
    assign bus.tx_data        = r_data;
    assign bus.tx_parity_type = r_parity;
    assign bus.tx_baud_rate   = r_baud;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: TX-unit model, ack/err scoreboard and scenario tasks.
module tb_uart_tx_arbiter;
    localparam int MODEL_DELAY = 3;
    localparam int FRAME       = 4;

    typedef struct {
        bit         is_err;
        int         id;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    bit   model_en;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input bit is_err, input int id, input logic [7:0] data);
        exp_t e;
        e.is_err = is_err;
        e.id     = id;
        e.data   = data;
        sb.push_back(e);
    endtask

    // TX unit model: tx_active MODEL_DELAY cycles after tx_send, FRAME active cycles, then tx_done.
    initial begin
        int         m_phase;
        int         m_cnt;
        logic [7:0] m_data;
        m_phase = 0;
        m_cnt   = 0;
        m_data  = '0;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                bus.tx_active = 1'b0;
                bus.tx_done   = 1'b0;
            end else begin
                case (m_phase)
                    0: if (model_en && bus.tx_send === 1'b1) begin
                        m_cnt   = MODEL_DELAY;
                        m_data  = bus.tx_data;
                        m_phase = 1;
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            bus.tx_active = 1'b1;
                            m_cnt   = FRAME;
                            m_phase = 2;
                        end
                    end
                    2: begin
                        n_checks++;
                        if (bus.tx_data !== m_data) begin
                            n_fail++;
                            $display("FAIL tx_data_stable: got %h expected %h", bus.tx_data, m_data);
                        end
                        m_cnt--;
                        if (m_cnt == 0) begin
                            bus.tx_active = 1'b0;
                            bus.tx_done   = 1'b1;
                            m_phase = 3;
                        end
                    end
                    default: begin
                        bus.tx_done = 1'b0;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard: every ack/err pulse pops one expected event.
    initial begin
        exp_t       e;
        logic [3:0] ev;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.ack !== 4'b0 || bus.err !== 4'b0)) begin
                n_checks++;
                if (((bus.ack & bus.err) !== 4'b0) || ($countones(bus.ack | bus.err) != 1)) begin
                    n_fail++;
                    $display("FAIL event_onehot: ack=%b err=%b expected a single bit", bus.ack, bus.err);
                end
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: ack=%b err=%b expected none", bus.ack, bus.err);
                end else begin
                    e  = sb.pop_front();
                    ev = 4'b0001 << e.id;
                    if (e.is_err ? (bus.err !== ev || bus.ack !== 4'b0)
                                 : (bus.ack !== ev || bus.err !== 4'b0)) begin
                        n_fail++;
                        $display("FAIL event_id: ack=%b err=%b expected %s for id %0d",
                                 bus.ack, bus.err, e.is_err ? "err" : "ack", e.id);
                    end
                    if (!e.is_err) begin
                        n_checks++;
                        if (bus.tx_data !== e.data) begin
                            n_fail++;
                            $display("FAIL ack_data: got %h expected %h", bus.tx_data, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.tx_send, bus.busy, bus.ack, bus.err} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: send=%b busy=%b ack=%b err=%b expected all 0",
                     bus.tx_send, bus.busy, bus.ack, bus.err);
        end
        n_checks++;
        if ({bus.grant_id, bus.tx_data, bus.tx_parity_type, bus.tx_baud_rate} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_data: grant=%0d data=%h par=%b baud=%b expected all 0",
                     bus.grant_id, bus.tx_data, bus.tx_parity_type, bus.tx_baud_rate);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit got;
        bus.cfg_parity_type = 2'b01;
        bus.cfg_baud_rate   = 2'b00;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        push_exp(1'b0, 0, 8'hA5);
        bus.req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx_send !== (c < 4) || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_send c=%0d: send=%b busy=%b expected send=%b busy=1",
                         c, bus.tx_send, bus.busy, c < 4);
            end
            n_checks++;
            if (bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL single_data c=%0d: data=%h grant=%0d expected a5 / 0",
                         c, bus.tx_data, bus.grant_id);
            end
        end
        n_checks++;
        if (bus.tx_parity_type !== 2'b01) begin
            n_fail++;
            $display("FAIL single_parity: got %b expected 01", bus.tx_parity_type);
        end
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ack: got ack=%b (seen=%b) expected 0001", bus.ack, got);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack_pulse: ack=%b busy=%b expected 0000 / 0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_rotation();
        bit got;
        apply_reset();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 5; i++) push_exp(1'b0, i % 4, 8'h10 + 8'(i % 4));
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin got = 1'b1; break; end
            end
            if (n == 4) bus.req = 4'b0000;
            n_checks++;
            if (!got || bus.grant_id !== 2'(n % 4)) begin
                n_fail++;
                $display("FAIL rotation_order n=%0d: grant=%0d (seen=%b) expected %0d",
                         n, bus.grant_id, got, n % 4);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_cfg_freeze();
        bit got;
        bus.req_data[15:8] = 8'h5A;
        bus.cfg_baud_rate  = 2'b00;
        push_exp(1'b0, 1, 8'h5A);
        bus.req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.tx_active === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL cfg_start_timeout: tx_active never seen, expected within 20 cycles");
        end
        @(negedge clk);
        bus.cfg_baud_rate = 2'b11;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            n_checks++;
            if (bus.tx_baud_rate !== 2'b00) begin
                n_fail++;
                $display("FAIL cfg_frozen c=%0d: baud=%b expected 00", c, bus.tx_baud_rate);
            end
            if (bus.ack !== 4'b0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (!got || bus.tx_baud_rate !== 2'b11) begin
            n_fail++;
            $display("FAIL cfg_update: baud=%b (ack seen=%b) expected 11", bus.tx_baud_rate, got);
        end
    endtask

    task automatic test_timeout();
        bit got;
        model_en = 1'b0;
        bus.req_data[23:16] = 8'h77;
        push_exp(1'b1, 2, 8'h00);
        bus.req = 4'b0100;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            n_checks++;
            if (c <= 16) begin
                if (bus.err !== 4'b0 || bus.tx_send !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_wait c=%0d: err=%b send=%b expected 0000 / 1",
                             c, bus.err, bus.tx_send);
                end
            end else if (c == 17) begin
                if (bus.err !== 4'b0100 || bus.tx_send !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_err: err=%b send=%b expected 0100 / 0", bus.err, bus.tx_send);
                end
                bus.req = 4'b0000;
            end else begin
                if (bus.err !== 4'b0 || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_after: err=%b busy=%b expected 0000 / 0", bus.err, bus.busy);
                end
            end
        end
        model_en = 1'b1;
        bus.req_data[31:24] = 8'h99;
        bus.req_data[7:0]   = 8'h88;
        push_exp(1'b0, 3, 8'h99);
        push_exp(1'b0, 0, 8'h88);
        bus.req = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin got = 1'b1; break; end
            end
            n_checks++;
            if (!got || bus.ack !== ((n == 0) ? 4'b1000 : 4'b0001)) begin
                n_fail++;
                $display("FAIL timeout_next n=%0d: ack=%b (seen=%b) expected %b",
                         n, bus.ack, got, (n == 0) ? 4'b1000 : 4'b0001);
            end
            bus.req = (n == 0) ? 4'b0001 : 4'b0000;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got;
        bus.req_data[15:8] = 8'hC3;
        push_exp(1'b0, 1, 8'hC3);
        bus.req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.tx_active === 1'b1) begin got = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!got || {bus.tx_send, bus.busy, bus.ack, bus.err} !== 10'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: send=%b busy=%b ack=%b err=%b (active seen=%b) expected all 0",
                     bus.tx_send, bus.busy, bus.ack, bus.err, got);
        end
        n_checks++;
        if ({bus.grant_id, bus.tx_data, bus.tx_parity_type, bus.tx_baud_rate} !== 14'b0) begin
            n_fail++;
            $display("FAIL rstmid_data: grant=%0d data=%h par=%b baud=%b expected all 0",
                     bus.grant_id, bus.tx_data, bus.tx_parity_type, bus.tx_baud_rate);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.tx_send !== 1'b1 || bus.grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_regrant: send=%b grant=%0d expected 1 / 1", bus.tx_send, bus.grant_id);
        end
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || bus.ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_ack: ack=%b (seen=%b) expected 0010", bus.ack, got);
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_drop_mid();
        bit got;
        bus.req_data[23:16] = 8'h3C;
        push_exp(1'b0, 2, 8'h3C);
        bus.req = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (bus.tx_send !== 1'b1 || bus.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_grant: send=%b grant=%0d expected 1 / 2", bus.tx_send, bus.grant_id);
        end
        bus.req = 4'b0000;
        bus.req_data[23:16] = 8'hFF;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tx_data !== 8'h3C) begin
                n_fail++;
                $display("FAIL drop_data c=%0d: data=%h expected 3c", c, bus.tx_data);
            end
            if (bus.ack !== 4'b0 || bus.err !== 4'b0) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || bus.ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL drop_ack: ack=%b (seen=%b) expected 0100", bus.ack, got);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_regrant: busy=%b expected 0", bus.busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_en = 1'b1;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.req_data = '0;
        bus.cfg_parity_type = 2'b00;
        bus.cfg_baud_rate   = 2'b00;
        test_reset();
        test_single();
        test_rotation();
        test_cfg_freeze();
        test_timeout();
        test_reset_mid();
        test_drop_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
